// File: rtl/seven_seg_pkg.sv
`timescale 1ns/1ps
// Shared constants for the seven-segment scan driver: segment ROM, off patterns, slot-state enum.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seven_seg_pkg;

   // Active-low segment patterns {dp, g..a} for hex digits 0..F; dp bit is kept off here
   localparam logic [7:0] SEG_ROM [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] DIG_OFF = 4'hF;

   // BLANK: anti-ghosting gap at the start of each slot; ON: selected digit lit
   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } slot_state_e;

endpackage

// File: rtl/hex_to_seg.sv
`timescale 1ns/1ps
// Nibble to active-low seven-segment pattern (g..a), decimal point handled by the caller.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_ROM[i_nibble][6:0];

endmodule

// File: rtl/seven_seg_scan_driver.sv
`timescale 1ns/1ps
// Scans a 4-digit common-anode hex display from a per-frame snapshot of value/dp/lz inputs.
// Latency: outputs registered from next-state; snapshot visible from the digit-0 slot of the next frame.
// Backpressure: none; free-running scan, inputs sampled once per frame.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        lz_en_in,
   output logic [7:0]  seg_out,
   output logic [3:0]  digit_out,
   output logic        frame_out
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] SLOT_ON   = CW'(BLANK_CYCLES);

   logic [CW-1:0] r_slot_cnt;
   logic [1:0]    r_digit_idx;
   logic [15:0]   r_snap_val;
   logic [3:0]    r_snap_dp;
   logic          r_snap_lz;
   slot_state_e   r_state;
   logic [7:0]    r_seg;
   logic [3:0]    r_digit;
   logic          r_frame;

   logic          w_slot_wrap;
   logic [CW-1:0] w_slot_nxt;
   logic [1:0]    w_idx_nxt;
   logic          w_frame_nxt;
   logic [15:0]   w_snap_val_nxt;
   logic [3:0]    w_snap_dp_nxt;
   logic          w_snap_lz_nxt;
   slot_state_e   w_state_nxt;
   logic [3:0]    w_nibble;
   logic [6:0]    w_seg7;
   logic          w_dark;
   logic [7:0]    w_seg_nxt;
   logic [3:0]    w_digit_nxt;

   // Slot counter, digit index and snapshot next values; snapshot reloads on entry to digit 0
   always_comb begin
      w_slot_wrap    = (r_slot_cnt == SLOT_LAST);
      w_slot_nxt     = w_slot_wrap ? '0 : r_slot_cnt + CW'(1);
      w_idx_nxt      = w_slot_wrap ? r_digit_idx + 2'd1 : r_digit_idx;
      w_frame_nxt    = w_slot_wrap && (r_digit_idx == 2'd3);
      w_snap_val_nxt = w_frame_nxt ? value_in : r_snap_val;
      w_snap_dp_nxt  = w_frame_nxt ? dp_in    : r_snap_dp;
      w_snap_lz_nxt  = w_frame_nxt ? lz_en_in : r_snap_lz;
   end

   // Counter and snapshot registers
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= 2'd0;
         r_snap_val  <= 16'h0000;
         r_snap_dp   <= 4'h0;
         r_snap_lz   <= 1'b0;
      end else begin
         r_slot_cnt  <= w_slot_nxt;
         r_digit_idx <= w_idx_nxt;
         r_snap_val  <= w_snap_val_nxt;
         r_snap_dp   <= w_snap_dp_nxt;
         r_snap_lz   <= w_snap_lz_nxt;
      end
   end

   // Slot FSM state register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= BLANK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Slot FSM next state: light up once the blank gap is over, go dark again at the slot boundary
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BLANK: if (w_slot_nxt == SLOT_ON) w_state_nxt = ON;
         ON:    if (w_slot_wrap)           w_state_nxt = BLANK;
      endcase
   end

   // Pick the nibble for the digit about to be shown
   assign w_nibble = w_snap_val_nxt[{w_idx_nxt, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .i_nibble (w_nibble),
      .o_seg    (w_seg7)
   );

   // Leading-zero suppression: a digit is dark when it and every digit to its left are zero
   always_comb begin
      w_dark = 1'b0;
      if (w_snap_lz_nxt) begin
         case (w_idx_nxt)
            2'd3:    w_dark = (w_snap_val_nxt[15:12] == 4'h0);
            2'd2:    w_dark = (w_snap_val_nxt[15:8]  == 8'h00);
            2'd1:    w_dark = (w_snap_val_nxt[15:4]  == 12'h000);
            default: w_dark = 1'b0;
         endcase
      end
   end

   // Slot FSM outputs: everything off in BLANK, one anode and its segments in ON
   always_comb begin
      w_seg_nxt   = SEG_OFF;
      w_digit_nxt = DIG_OFF;
      if (w_state_nxt == ON) begin
         w_digit_nxt = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt   = {~w_snap_dp_nxt[w_idx_nxt], (w_dark ? 7'h7F : w_seg7)};
      end
   end

   // Output registers so pins change on the same edge as the slot counter
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_seg   <= SEG_OFF;
         r_digit <= DIG_OFF;
         r_frame <= 1'b0;
      end else begin
         r_seg   <= w_seg_nxt;
         r_digit <= w_digit_nxt;
         r_frame <= w_frame_nxt;
      end
   end

   assign seg_out   = r_seg;
   assign digit_out = r_digit;
   assign frame_out = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues expected per-cycle outputs, a negedge monitor pops and compares.
// Latency: frame expectations are queued at the start of the frame they describe.
// Backpressure: n/a.
module tb_seven_seg_scan_driver;

   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FRAME = 4 * DC;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        lz_en_in;
   logic [7:0]  seg_out;
   logic [3:0]  digit_out;
   logic        frame_out;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] dig;
      logic       frm;
      int         tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Hex decode table written out independently of the design
   logic [7:0] dec_tbl [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   seven_seg_scan_driver #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .value_in      (value_in),
      .dp_in         (dp_in),
      .lz_en_in      (lz_en_in),
      .seg_out       (seg_out),
      .digit_out     (digit_out),
      .frame_out     (frame_out)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string name, input int tag, input logic [12:0] act, input logic [12:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s tag=%0d actual seg=%h dig=%h frm=%b required seg=%h dig=%h frm=%b",
                  name, tag, act[12:5], act[4:1], act[0], req[12:5], req[4:1], req[0]);
      end
   endtask

   task automatic push_off(input int tag);
      exp_t e;
      e.seg = 8'hFF;
      e.dig = 4'hF;
      e.frm = 1'b0;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Expected outputs for one full frame, cycle 0 being the first cycle after the frame boundary
   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic lz,
                             input logic pulse, input int fid);
      for (int c = 0; c < FRAME; c++) begin
         exp_t        e;
         int          d;
         int          s;
         logic [15:0] sh;
         logic        dark;
         logic [7:0]  code;
         d = c / DC;
         s = c % DC;
         e.tag = fid * 100 + c;
         e.frm = pulse && (c == 0);
         if (s < BC) begin
            e.seg = 8'hFF;
            e.dig = 4'hF;
         end else begin
            sh   = v >> (4 * d);
            dark = lz && (d > 0) && (sh == 16'h0000);
            code = dec_tbl[sh[3:0]];
            e.dig = 4'hF & ~(4'b0001 << d);
            e.seg = {~dp[d], (dark ? 7'h7F : code[6:0])};
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   // Monitor: every cycle with a pending expectation is compared
   always @(negedge clk_clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scan", e.tag, {seg_out, digit_out, frame_out}, {e.seg, e.dig, e.frm});
      end
   end

   initial begin
      reset_reset_n = 1'b1;
      value_in      = 16'h0000;
      dp_in         = 4'h0;
      lz_en_in      = 1'b0;
      #1;
      reset_reset_n = 1'b0;
      @(posedge clk_clk);
      #1;
      for (int i = 0; i < 3; i++) push_off(900 + i);
      wait_cyc(3);

      // Frame 0 after release shows the reset snapshot "0000" with no frame pulse
      reset_reset_n = 1'b1;
      push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 0);
      value_in = 16'h12AF;
      wait_cyc(FRAME);

      // Frame 1: plain scan of 12AF
      push_frame(16'h12AF, 4'h0, 1'b0, 1'b1, 1);
      value_in = 16'h1234;
      wait_cyc(FRAME);

      // Frame 2: 1234 stays on screen though the input changes mid-frame
      push_frame(16'h1234, 4'h0, 1'b0, 1'b1, 2);
      wait_cyc(13);
      value_in = 16'h5678;
      wait_cyc(FRAME - 13);

      // Frame 3: the new value appears only now
      push_frame(16'h5678, 4'h0, 1'b0, 1'b1, 3);
      value_in = 16'h0050;
      lz_en_in = 1'b1;
      wait_cyc(FRAME);

      // Frame 4: leading zeros suppressed, interior digits kept
      push_frame(16'h0050, 4'h0, 1'b1, 1'b1, 4);
      value_in = 16'h0000;
      wait_cyc(FRAME);

      // Frame 5: all-zero value, digit 0 still shown
      push_frame(16'h0000, 4'h0, 1'b1, 1'b1, 5);
      value_in = 16'h0008;
      dp_in    = 4'b0100;
      wait_cyc(FRAME);

      // Frame 6: dp stays lit on a suppressed digit
      push_frame(16'h0008, 4'b0100, 1'b1, 1'b1, 6);
      value_in = 16'h0F00;
      dp_in    = 4'b0001;
      wait_cyc(FRAME);

      // Frame 7: zeros to the right of a non-zero digit are not suppressed; reset lands in digit 2 ON
      push_frame(16'h0F00, 4'b0001, 1'b1, 1'b1, 7);
      wait_cyc(2 * DC + BC + 1);
      @(negedge clk_clk);
      #1;
      exp_q.delete();
      check("pre_reset_lit", 700, {seg_out, digit_out, frame_out}, {8'h8E, 4'hB, 1'b0});
      reset_reset_n = 1'b0;
      #1;
      check("async_reset", 701, {seg_out, digit_out, frame_out}, {8'hFF, 4'hF, 1'b0});
      @(posedge clk_clk);
      #1;
      for (int i = 0; i < 3; i++) push_off(710 + i);
      wait_cyc(3);

      // Frame 8: restart from digit 0 showing the cleared snapshot
      reset_reset_n = 1'b1;
      push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 8);
      wait_cyc(FRAME);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
